// File: rtl/clock_meter.sv
// Measures period, high time, low time and phase (vs. ref_in) of an asynchronous
// pulse train, all counted in cycles of clk.
module clock_meter #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  input  logic             ref_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] ton,
  output logic [CNT_W-1:0] toff,
  output logic [CNT_W-1:0] phase,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  // Synchronizers and edge detection
  logic [SYNC_STAGES-1:0] sig_sync_q;
  logic [SYNC_STAGES-1:0] ref_sync_q;
  logic                   sig_prev_q;
  logic                   ref_prev_q;
  logic                   sig_s;
  logic                   ref_s;
  logic                   sig_rise;
  logic                   sig_fall;
  logic                   ref_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_sync_q <= '0;
      ref_sync_q <= '0;
      sig_prev_q <= 1'b0;
      ref_prev_q <= 1'b0;
    end else begin
      sig_sync_q <= {sig_sync_q[SYNC_STAGES-2:0], sig_in};
      ref_sync_q <= {ref_sync_q[SYNC_STAGES-2:0], ref_in};
      sig_prev_q <= sig_s;
      ref_prev_q <= ref_s;
    end
  end

  assign sig_s    = sig_sync_q[SYNC_STAGES-1];
  assign ref_s    = ref_sync_q[SYNC_STAGES-1];
  assign sig_rise = sig_s & ~sig_prev_q;
  assign sig_fall = ~sig_s & sig_prev_q;
  assign ref_rise = ref_s & ~ref_prev_q;

  // Phase counter: phase_now is the distance from the latest ref rise as seen
  // in the current cycle, so a coincident ref rise reads as zero.
  logic [CNT_W-1:0] phase_cnt_q;
  logic [CNT_W-1:0] phase_cnt_d;
  logic [CNT_W-1:0] phase_now;
  logic [CNT_W-1:0] phase_sample;
  logic             ref_seen_q;
  logic             ref_seen_d;

  always_comb begin
    phase_now    = ref_rise ? '0 : phase_cnt_q;
    phase_cnt_d  = (phase_now == CNT_MAX) ? CNT_MAX : phase_now + ONE;
    ref_seen_d   = ref_seen_q | ref_rise;
    phase_sample = ref_seen_d ? phase_now : CNT_MAX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt_q <= '0;
      ref_seen_q  <= 1'b0;
    end else begin
      phase_cnt_q <= phase_cnt_d;
      ref_seen_q  <= ref_seen_d;
    end
  end

  // Measurement FSM
  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] ton_r_q;
  logic [CNT_W-1:0] ton_r_d;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] period_d;
  logic [CNT_W-1:0] ton_q;
  logic [CNT_W-1:0] ton_d;
  logic [CNT_W-1:0] toff_q;
  logic [CNT_W-1:0] toff_d;
  logic [CNT_W-1:0] phase_q;
  logic [CNT_W-1:0] phase_d;
  logic             timeout_q;
  logic             timeout_d;
  logic             meas_valid_q;
  logic             meas_valid_d;
  logic             edge_hit;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ton_r_d      = ton_r_q;
    period_d     = period_q;
    ton_d        = ton_q;
    toff_d       = toff_q;
    phase_d      = phase_q;
    timeout_d    = timeout_q;
    meas_valid_d = 1'b0;
    // HIGH waits for a fall; IDLE and LOW wait for a rise.
    edge_hit     = (state_q == HIGH) ? sig_fall : sig_rise;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (edge_hit) begin
      cnt_d = ONE;
      case (state_q)
        IDLE: state_d = HIGH;
        HIGH: begin
          state_d = LOW;
          ton_r_d = cnt_q;
        end
        LOW: begin
          state_d      = HIGH;
          ton_d        = ton_r_q;
          toff_d       = cnt_q;
          period_d     = ton_r_q + cnt_q;
          phase_d      = phase_sample;
          meas_valid_d = 1'b1;
          timeout_d    = 1'b0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end else if (cnt_q >= TIMEOUT_C) begin
      timeout_d = 1'b1;
      state_d   = IDLE;
      cnt_d     = '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ton_r_q      <= '0;
      period_q     <= '0;
      ton_q        <= '0;
      toff_q       <= '0;
      phase_q      <= '0;
      timeout_q    <= 1'b0;
      meas_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ton_r_q      <= ton_r_d;
      period_q     <= period_d;
      ton_q        <= ton_d;
      toff_q       <= toff_d;
      phase_q      <= phase_d;
      timeout_q    <= timeout_d;
      meas_valid_q <= meas_valid_d;
    end
  end

  assign meas_valid = meas_valid_q;
  assign period     = period_q;
  assign ton        = ton_q;
  assign toff       = toff_q;
  assign phase      = phase_q;
  assign timeout    = timeout_q;

endmodule
